// File: rtl/mapper_pkg.sv
// Shared encodings and reset constants for the serial-load bank mapper.
package mapper_pkg;

    typedef enum logic [1:0] {
        REG_CONTROL = 2'b00,
        REG_CHR0    = 2'b01,
        REG_CHR1    = 2'b10,
        REG_PRG     = 2'b11
    } reg_sel_t;

    localparam logic [1:0] MIRROR_SINGLE_LO = 2'b00;
    localparam logic [1:0] MIRROR_SINGLE_HI = 2'b01;
    localparam logic [1:0] MIRROR_VERTICAL  = 2'b10;
    localparam logic [1:0] MIRROR_HORIZ     = 2'b11;

    localparam logic [1:0] PRG_MODE_32K_A   = 2'b00;
    localparam logic [1:0] PRG_MODE_32K_B   = 2'b01;
    localparam logic [1:0] PRG_MODE_FIX_LO  = 2'b10;
    localparam logic [1:0] PRG_MODE_FIX_HI  = 2'b11;

    localparam logic [4:0] SHIFT_INIT   = 5'b10000;
    localparam logic [4:0] CONTROL_INIT = 5'b01100;

endpackage

// File: rtl/serial_load_shifter.sv
// Five-bit serial loader with consecutive-write filter; emits one-edge commit and D7 reset strobes.
module serial_load_shifter
    import mapper_pkg::*;
#(
    parameter bit IGNORE_CONSECUTIVE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       d0,
    input  logic       d7,
    input  logic       a13,
    input  logic       a14,
    output logic       commit,
    output logic       d7_reset,
    output logic [4:0] value,
    output reg_sel_t   sel
);

    logic [4:0] shift;
    logic       last_wr;
    logic       accept;

    // The strobes are combinational so the bank registers load on the same falling edge.
    assign accept   = wr & ~(IGNORE_CONSECUTIVE & last_wr);
    assign d7_reset = accept & d7;
    assign commit   = accept & ~d7 & shift[0];
    assign value    = {d0, shift[4:1]};
    assign sel      = reg_sel_t'({a14, a13});

    always_ff @(negedge clk) begin
        if (rst) begin
            shift   <= SHIFT_INIT;
            last_wr <= 1'b0;
        end else begin
            last_wr <= wr;
            if (d7_reset || commit) begin
                shift <= SHIFT_INIT;
            end else if (accept) begin
                shift <= value;
            end
        end
    end

endmodule

// File: rtl/serial_bank_mapper.sv
// MMC1-class mapper: bank registers loaded serially, with combinational PRG/CHR/WRAM/CIRAM decode.
module serial_bank_mapper
    import mapper_pkg::*;
#(
    parameter int PRG_BANK_BITS      = 4,
    parameter int CHR_BANK_BITS      = 5,
    parameter bit IGNORE_CONSECUTIVE = 1'b1,
    parameter bit OUTER_PRG          = 1'b0
) (
    input  logic                     CPU_M2,
    input  logic                     RST,
    input  logic                     CPU_A13,
    input  logic                     CPU_A14,
    input  logic                     nCPU_ROMSEL,
    input  logic                     nCPU_RW,
    input  logic                     CPU_D0,
    input  logic                     CPU_D7,
    input  logic                     PPU_A12,
    input  logic                     PPU_A11,
    input  logic                     PPU_A10,
    output logic                     CIRAM_A10,
    output logic [PRG_BANK_BITS-1:0] PRG_A,
    output logic                     PRG_A_OUTER,
    output logic                     nPRG_CE,
    output logic                     nWRAM_CE,
    output logic [CHR_BANK_BITS-1:0] CHR_A
);

    logic [4:0] control, chr0, chr1, prg;
    logic       wr, commit, d7_reset;
    logic [4:0] value;
    reg_sel_t   sel;

    assign wr = ~nCPU_ROMSEL & ~nCPU_RW;

    serial_load_shifter #(
        .IGNORE_CONSECUTIVE(IGNORE_CONSECUTIVE)
    ) u_shifter (
        .clk      (CPU_M2),
        .rst      (RST),
        .wr       (wr),
        .d0       (CPU_D0),
        .d7       (CPU_D7),
        .a13      (CPU_A13),
        .a14      (CPU_A14),
        .commit   (commit),
        .d7_reset (d7_reset),
        .value    (value),
        .sel      (sel)
    );

    always_ff @(negedge CPU_M2) begin
        if (RST) begin
            control <= CONTROL_INIT;
            chr0    <= 5'b00000;
            chr1    <= 5'b00000;
            prg     <= 5'b00000;
        end else if (d7_reset) begin
            control <= control | CONTROL_INIT;
        end else if (commit) begin
            case (sel)
                REG_CONTROL: control <= value;
                REG_CHR0:    chr0    <= value;
                REG_CHR1:    chr1    <= value;
                REG_PRG:     prg     <= value;
                default:     prg     <= value;
            endcase
        end
    end

    always_comb begin
        CIRAM_A10 = 1'b0;
        case (control[1:0])
            MIRROR_SINGLE_LO: CIRAM_A10 = 1'b0;
            MIRROR_SINGLE_HI: CIRAM_A10 = 1'b1;
            MIRROR_VERTICAL:  CIRAM_A10 = PPU_A10;
            MIRROR_HORIZ:     CIRAM_A10 = PPU_A11;
            default:          CIRAM_A10 = 1'b0;
        endcase
    end

    logic [PRG_BANK_BITS-1:0] prg_bank, prg_bank_32k;

    // In 32 KB mode the bank's low bit is replaced by CPU A14 rather than sliced off.
    always_comb begin
        prg_bank        = prg[PRG_BANK_BITS-1:0];
        prg_bank_32k    = prg_bank;
        prg_bank_32k[0] = CPU_A14;
        PRG_A           = prg_bank;
        case (control[3:2])
            PRG_MODE_32K_A,
            PRG_MODE_32K_B:  PRG_A = prg_bank_32k;
            PRG_MODE_FIX_LO: PRG_A = CPU_A14 ? prg_bank : '0;
            PRG_MODE_FIX_HI: PRG_A = CPU_A14 ? '1 : prg_bank;
            default:         PRG_A = prg_bank;
        endcase
    end

    logic [CHR_BANK_BITS-1:0] chr_bank_8k;

    always_comb begin
        chr_bank_8k    = chr0[CHR_BANK_BITS-1:0];
        chr_bank_8k[0] = PPU_A12;
        if (control[4]) begin
            CHR_A = PPU_A12 ? chr1[CHR_BANK_BITS-1:0] : chr0[CHR_BANK_BITS-1:0];
        end else begin
            CHR_A = chr_bank_8k;
        end
    end

    assign PRG_A_OUTER = OUTER_PRG & chr0[4];
    assign nPRG_CE     = nCPU_ROMSEL | ~nCPU_RW;
    assign nWRAM_CE    = ~(nCPU_ROMSEL & CPU_M2 & CPU_A14 & CPU_A13 & ~prg[4]);

endmodule

// File: tb/tb_serial_bank_mapper.sv
// Directed bench for serial_bank_mapper: a filtered default instance and an unfiltered outer-PRG instance.
module tb_serial_bank_mapper;

    logic CPU_M2 = 1'b1;
    logic RST, CPU_A13, CPU_A14, nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7;
    logic PPU_A12, PPU_A11, PPU_A10;

    logic       ciram_a10, prg_a_outer, nprg_ce, nwram_ce;
    logic [3:0] prg_a;
    logic [4:0] chr_a;
    logic       nf_ciram_a10, nf_prg_a_outer, nf_nprg_ce, nf_nwram_ce;
    logic [3:0] nf_prg_a;
    logic [4:0] nf_chr_a;

    int compared = 0;
    int mismatched = 0;

    always #5 CPU_M2 = ~CPU_M2;

    serial_bank_mapper dut (
        .CPU_M2(CPU_M2), .RST(RST), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
        .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .PPU_A12(PPU_A12), .PPU_A11(PPU_A11), .PPU_A10(PPU_A10),
        .CIRAM_A10(ciram_a10), .PRG_A(prg_a), .PRG_A_OUTER(prg_a_outer),
        .nPRG_CE(nprg_ce), .nWRAM_CE(nwram_ce), .CHR_A(chr_a)
    );

    serial_bank_mapper #(
        .PRG_BANK_BITS(4), .CHR_BANK_BITS(5), .IGNORE_CONSECUTIVE(1'b0), .OUTER_PRG(1'b1)
    ) dut_nf (
        .CPU_M2(CPU_M2), .RST(RST), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
        .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .PPU_A12(PPU_A12), .PPU_A11(PPU_A11), .PPU_A10(PPU_A10),
        .CIRAM_A10(nf_ciram_a10), .PRG_A(nf_prg_a), .PRG_A_OUTER(nf_prg_a_outer),
        .nPRG_CE(nf_nprg_ce), .nWRAM_CE(nf_nwram_ce), .CHR_A(nf_chr_a)
    );

    task automatic bus_idle();
        nCPU_ROMSEL = 1'b1;
        nCPU_RW     = 1'b1;
        CPU_D7      = 1'b0;
    endtask

    task automatic tick();
        @(negedge CPU_M2);
        #1;
    endtask

    // One write cycle committed at the next falling edge; the bus goes idle right after.
    task automatic cpu_write(input logic a14, input logic a13, input logic d0, input logic d7);
        CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7;
        nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic serial_write(input logic a14, input logic a13, input logic d0, input logic d7);
        cpu_write(a14, a13, d0, d7);
        tick();
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [4:0] val);
        for (int i = 0; i < 5; i++) serial_write(sel[1], sel[0], val[i], 1'b0);
    endtask

    task automatic cpu_read(input logic a14, input logic a13);
        CPU_A14 = a14; CPU_A13 = a13;
        nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b1;
        @(posedge CPU_M2);
        #1;
    endtask

    task automatic wram_access();
        CPU_A14 = 1'b1; CPU_A13 = 1'b1;
        nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
        @(posedge CPU_M2);
        #1;
    endtask

    task automatic do_reset();
        bus_idle();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        PPU_A12 = 1'b1; PPU_A11 = 1'b1; PPU_A10 = 1'b1;
        cpu_read(1'b1, 1'b0);
        compared++; if (prg_a !== 4'b1111) begin mismatched++; $display("FAIL reset_prg_c000: got %b want 1111", prg_a); end
        compared++; if (ciram_a10 !== 1'b0) begin mismatched++; $display("FAIL reset_ciram: got %b want 0", ciram_a10); end
        compared++; if (nprg_ce !== 1'b0) begin mismatched++; $display("FAIL reset_nprg_ce_read: got %b want 0", nprg_ce); end
        compared++; if (chr_a !== 5'b00001) begin mismatched++; $display("FAIL reset_chr_8k: got %b want 00001", chr_a); end
        compared++; if (prg_a_outer !== 1'b0 || nf_prg_a_outer !== 1'b0) begin mismatched++; $display("FAIL reset_outer: got %b/%b want 0/0", prg_a_outer, nf_prg_a_outer); end
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0000) begin mismatched++; $display("FAIL reset_prg_8000: got %b want 0000", prg_a); end
        wram_access();
        compared++; if (nwram_ce !== 1'b0) begin mismatched++; $display("FAIL reset_nwram_ce: got %b want 0", nwram_ce); end
        compared++; if (nprg_ce !== 1'b1) begin mismatched++; $display("FAIL reset_nprg_ce_idle: got %b want 1", nprg_ce); end
        bus_idle();
    endtask

    task automatic test_prg_modes();
        do_reset();
        write_reg(2'b11, 5'b00101);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0101) begin mismatched++; $display("FAIL prg_fixhi_8000: got %b want 0101", prg_a); end
        cpu_read(1'b1, 1'b0);
        compared++; if (prg_a !== 4'b1111) begin mismatched++; $display("FAIL prg_fixhi_c000: got %b want 1111", prg_a); end
        write_reg(2'b00, 5'b01000);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0000) begin mismatched++; $display("FAIL prg_fixlo_8000: got %b want 0000", prg_a); end
        cpu_read(1'b1, 1'b0);
        compared++; if (prg_a !== 4'b0101) begin mismatched++; $display("FAIL prg_fixlo_c000: got %b want 0101", prg_a); end
        write_reg(2'b00, 5'b00000);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0100) begin mismatched++; $display("FAIL prg_32k_8000: got %b want 0100", prg_a); end
        cpu_read(1'b1, 1'b0);
        compared++; if (prg_a !== 4'b0101) begin mismatched++; $display("FAIL prg_32k_c000: got %b want 0101", prg_a); end
        bus_idle();
    endtask

    task automatic test_mirroring();
        do_reset();
        write_reg(2'b00, 5'b00010);
        PPU_A10 = 1'b1; PPU_A11 = 1'b0; #1;
        compared++; if (ciram_a10 !== 1'b1) begin mismatched++; $display("FAIL mirror_vert_hi: got %b want 1", ciram_a10); end
        PPU_A10 = 1'b0; PPU_A11 = 1'b1; #1;
        compared++; if (ciram_a10 !== 1'b0) begin mismatched++; $display("FAIL mirror_vert_lo: got %b want 0", ciram_a10); end
        write_reg(2'b00, 5'b00011);
        PPU_A10 = 1'b0; PPU_A11 = 1'b1; #1;
        compared++; if (ciram_a10 !== 1'b1) begin mismatched++; $display("FAIL mirror_horiz: got %b want 1", ciram_a10); end
        write_reg(2'b00, 5'b00001);
        PPU_A10 = 1'b0; PPU_A11 = 1'b0; #1;
        compared++; if (ciram_a10 !== 1'b1) begin mismatched++; $display("FAIL mirror_single_hi: got %b want 1", ciram_a10); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cpu_write(1'b1, 1'b1, 1'b1, 1'b0);
        cpu_write(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        serial_write(1'b1, 1'b1, 1'b0, 1'b0);
        serial_write(1'b1, 1'b1, 1'b0, 1'b0);
        serial_write(1'b1, 1'b1, 1'b0, 1'b0);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0000) begin mismatched++; $display("FAIL filter_no_commit_yet: got %b want 0000", prg_a); end
        compared++; if (nf_prg_a !== 4'b0011) begin mismatched++; $display("FAIL nofilter_commit: got %b want 0011", nf_prg_a); end
        bus_idle();
        serial_write(1'b1, 1'b1, 1'b1, 1'b0);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0001) begin mismatched++; $display("FAIL filter_commit: got %b want 0001", prg_a); end
        compared++; if (nf_prg_a !== 4'b0011) begin mismatched++; $display("FAIL nofilter_hold: got %b want 0011", nf_prg_a); end
        wram_access();
        compared++; if (nwram_ce !== 1'b1) begin mismatched++; $display("FAIL filter_wram_off: got %b want 1", nwram_ce); end
        compared++; if (nf_nwram_ce !== 1'b0) begin mismatched++; $display("FAIL nofilter_wram_on: got %b want 0", nf_nwram_ce); end
        bus_idle();
    endtask

    task automatic test_chr_banks();
        do_reset();
        write_reg(2'b00, 5'b10000);
        write_reg(2'b01, 5'b00011);
        write_reg(2'b10, 5'b00110);
        PPU_A12 = 1'b0; #1;
        compared++; if (chr_a !== 5'b00011) begin mismatched++; $display("FAIL chr4k_lo: got %b want 00011", chr_a); end
        PPU_A12 = 1'b1; #1;
        compared++; if (chr_a !== 5'b00110) begin mismatched++; $display("FAIL chr4k_hi: got %b want 00110", chr_a); end
        write_reg(2'b00, 5'b00000);
        PPU_A12 = 1'b0; #1;
        compared++; if (chr_a !== 5'b00010) begin mismatched++; $display("FAIL chr8k_lo: got %b want 00010", chr_a); end
        PPU_A12 = 1'b1; #1;
        compared++; if (chr_a !== 5'b00011) begin mismatched++; $display("FAIL chr8k_hi: got %b want 00011", chr_a); end
        write_reg(2'b00, 5'b10000);
        write_reg(2'b01, 5'b10011);
        PPU_A12 = 1'b0; #1;
        compared++; if (chr_a !== 5'b10011) begin mismatched++; $display("FAIL chr4k_bit4: got %b want 10011", chr_a); end
        compared++; if (prg_a_outer !== 1'b0) begin mismatched++; $display("FAIL outer_tied_low: got %b want 0", prg_a_outer); end
        compared++; if (nf_prg_a_outer !== 1'b1) begin mismatched++; $display("FAIL outer_from_chr0: got %b want 1", nf_prg_a_outer); end
    endtask

    task automatic test_d7_reset();
        do_reset();
        write_reg(2'b11, 5'b10000);
        wram_access();
        compared++; if (nwram_ce !== 1'b1) begin mismatched++; $display("FAIL wram_disabled: got %b want 1", nwram_ce); end
        bus_idle();
        write_reg(2'b00, 5'b10010);
        serial_write(1'b0, 1'b0, 1'b1, 1'b0);
        serial_write(1'b0, 1'b0, 1'b1, 1'b0);
        serial_write(1'b0, 1'b0, 1'b0, 1'b1);
        cpu_read(1'b1, 1'b0);
        compared++; if (prg_a !== 4'b1111) begin mismatched++; $display("FAIL d7_mode_fixhi: got %b want 1111", prg_a); end
        PPU_A10 = 1'b1; PPU_A11 = 1'b0; #1;
        compared++; if (ciram_a10 !== 1'b1) begin mismatched++; $display("FAIL d7_keeps_mirror: got %b want 1", ciram_a10); end
        bus_idle();
        write_reg(2'b11, 5'b00111);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0111) begin mismatched++; $display("FAIL d7_clean_reload: got %b want 0111", prg_a); end
        bus_idle();
        // A D7 write right after another write must be swallowed by the filter.
        cpu_write(1'b1, 1'b1, 1'b0, 1'b0);
        cpu_write(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        serial_write(1'b1, 1'b1, 1'b1, 1'b0);
        serial_write(1'b1, 1'b1, 1'b0, 1'b0);
        serial_write(1'b1, 1'b1, 1'b0, 1'b0);
        serial_write(1'b1, 1'b1, 1'b0, 1'b0);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0010) begin mismatched++; $display("FAIL d7_filtered: got %b want 0010", prg_a); end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_reg(2'b00, 5'b00001);
        serial_write(1'b1, 1'b1, 1'b1, 1'b0);
        serial_write(1'b1, 1'b1, 1'b1, 1'b0);
        serial_write(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset();
        PPU_A10 = 1'b1; PPU_A11 = 1'b1;
        cpu_read(1'b1, 1'b0);
        compared++; if (prg_a !== 4'b1111) begin mismatched++; $display("FAIL midreset_c000: got %b want 1111", prg_a); end
        compared++; if (ciram_a10 !== 1'b0) begin mismatched++; $display("FAIL midreset_ciram: got %b want 0", ciram_a10); end
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b0000) begin mismatched++; $display("FAIL midreset_8000: got %b want 0000", prg_a); end
        bus_idle();
        write_reg(2'b11, 5'b01010);
        cpu_read(1'b0, 1'b0);
        compared++; if (prg_a !== 4'b1010) begin mismatched++; $display("FAIL midreset_reload: got %b want 1010", prg_a); end
        bus_idle();
    endtask

    initial begin
        RST = 1'b1;
        CPU_A13 = 1'b0; CPU_A14 = 1'b0; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
        nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
        PPU_A12 = 1'b0; PPU_A11 = 1'b0; PPU_A10 = 1'b0;
        test_reset();
        test_prg_modes();
        test_mirroring();
        test_back_to_back();
        test_chr_banks();
        test_d7_reset();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
